calc_key_sequencer: RTL and testbench

Keypad-driven control FSM for the single-digit calculator datapath. It turns raw scanner output (`key`, `pressed`) into one-shot operand load strobes, an operator select, and a start/done handshake with the arithmetic unit. It also drives the display state code. It sits between the keypad scanner and the operand/answer storage, and replaces ad-hoc level enables with edge-qualified, single-cycle strobes.

---
 rtl/calc_pkg.sv | 45 ++++
 rtl/key_event_detect.sv | 28 ++
 rtl/calc_key_sequencer.sv | 147 ++++++++++++++
 tb/tb_calc_key_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared encodings for the single-digit calculator: display states, key codes, operator codes.
package calc_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned KEY_W   = 4;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned TIMER_W = 8;

  typedef enum logic [STATE_W-1:0] {
    S_LEFT  = 3'd0,
    S_RIGHT = 3'd1,
    S_CALC  = 3'd2,
    S_SHOW  = 3'd3
  } state_e;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10
  } op_e;

  localparam logic [KEY_W-1:0] KEY_DIG_MAX = 4'h9;
  localparam logic [KEY_W-1:0] KEY_ADD     = 4'hA;
  localparam logic [KEY_W-1:0] KEY_SUB     = 4'hB;
  localparam logic [KEY_W-1:0] KEY_MUL     = 4'hC;
  localparam logic [KEY_W-1:0] KEY_EQ      = 4'hE;
  localparam logic [KEY_W-1:0] KEY_CLR     = 4'hF;

  function automatic logic is_digit(input logic [KEY_W-1:0] k);
    return k <= KEY_DIG_MAX;
  endfunction

  function automatic logic is_oper(input logic [KEY_W-1:0] k);
    return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL);
  endfunction

  function automatic op_e key_to_op(input logic [KEY_W-1:0] k);
    case (k)
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/key_event_detect.sv
// Rising-edge detector on the scanner key-down level; one event per press, key sampled on that edge.
module key_event_detect
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key,
  input  logic             pressed,
  output logic             evt_c,
  output logic [KEY_W-1:0] evt_key_c
);

  logic pressed_d;
  logic pressed_q;

  // Resets high so a key held through reset release is not seen as a new press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pressed_q <= 1'b1;
    else        pressed_q <= pressed_d;
  end

  always_comb begin
    pressed_d = pressed;
    evt_c     = pressed & ~pressed_q;
    evt_key_c = key;
  end

endmodule

// File: rtl/calc_key_sequencer.sv
// Keypad control FSM: turns key events into operand load strobes, operator select and ALU handshake.
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned CALC_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key,
  input  logic       pressed,
  input  logic       calc_done,
  output logic       load_left,
  output logic       load_right,
  output logic       clr,
  output logic [1:0] op,
  output logic       calc_start,
  output logic       ans_enable,
  output logic       err,
  output logic [2:0] state
);

  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(CALC_TIMEOUT - 1);

  logic             evt_c;
  logic [KEY_W-1:0] evt_key_c;

  state_e             state_d, state_q;
  op_e                op_d, op_q;
  logic               err_d, err_q;
  logic               rv_d, rv_q;
  logic [TIMER_W-1:0] timer_d, timer_q;
  logic               ll_d, ll_q;
  logic               lr_d, lr_q;
  logic               clr_d, clr_q;
  logic               cs_d, cs_q;
  logic               ans_d, ans_q;

  key_event_detect u_key_event_detect (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .pressed   (pressed),
    .evt_c     (evt_c),
    .evt_key_c (evt_key_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LEFT;
      op_q    <= OP_ADD;
      err_q   <= 1'b0;
      rv_q    <= 1'b0;
      timer_q <= '0;
      ll_q    <= 1'b0;
      lr_q    <= 1'b0;
      clr_q   <= 1'b0;
      cs_q    <= 1'b0;
      ans_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
      timer_q <= timer_d;
      ll_q    <= ll_d;
      lr_q    <= lr_d;
      clr_q   <= clr_d;
      cs_q    <= cs_d;
      ans_q   <= ans_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    rv_d    = rv_q;
    timer_d = timer_q;
    ll_d    = 1'b0;
    lr_d    = 1'b0;
    clr_d   = 1'b0;
    cs_d    = 1'b0;

    // Clear beats everything, including a coincident calc_done.
    if (evt_c && (evt_key_c == KEY_CLR)) begin
      state_d = S_LEFT;
      op_d    = OP_ADD;
      err_d   = 1'b0;
      rv_d    = 1'b0;
      clr_d   = 1'b1;
    end else begin
      case (state_q)
        S_LEFT: begin
          if (evt_c && is_digit(evt_key_c)) begin
            ll_d = 1'b1;
          end else if (evt_c && is_oper(evt_key_c)) begin
            op_d    = key_to_op(evt_key_c);
            state_d = S_RIGHT;
          end
        end
        S_RIGHT: begin
          if (evt_c && is_digit(evt_key_c)) begin
            lr_d = 1'b1;
            rv_d = 1'b1;
          end else if (evt_c && is_oper(evt_key_c)) begin
            op_d = key_to_op(evt_key_c);
          end else if (evt_c && (evt_key_c == KEY_EQ) && rv_q) begin
            cs_d    = 1'b1;
            timer_d = '0;
            state_d = S_CALC;
          end
        end
        S_CALC: begin
          timer_d = timer_q + TIMER_W'(1);
          if (calc_done) begin
            err_d   = 1'b0;
            state_d = S_SHOW;
          end else if (timer_d == TIMEOUT_LAST) begin
            err_d   = 1'b1;
            state_d = S_SHOW;
          end
        end
        S_SHOW: begin
          if (evt_c && is_digit(evt_key_c)) begin
            ll_d    = 1'b1;
            err_d   = 1'b0;
            rv_d    = 1'b0;
            state_d = S_LEFT;
          end
        end
        default: state_d = S_LEFT;
      endcase
    end

    ans_d = (state_d == S_SHOW);
  end

  assign load_left  = ll_q;
  assign load_right = lr_q;
  assign clr        = clr_q;
  assign op         = op_q;
  assign calc_start = cs_q;
  assign ans_enable = ans_q;
  assign err        = err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench for calc_key_sequencer: cycle vector table plus hand-written multi-cycle sequences.
module tb_calc_key_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic       pressed;
  logic       calc_done;
  logic       load_left, load_right, clr, calc_start, ans_enable, err;
  logic [1:0] op;
  logic [2:0] state;

  int checks = 0;
  int passes = 0;

  calc_key_sequencer #(.CALC_TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .pressed    (pressed),
    .calc_done  (calc_done),
    .load_left  (load_left),
    .load_right (load_right),
    .clr        (clr),
    .op         (op),
    .calc_start (calc_start),
    .ans_enable (ans_enable),
    .err        (err),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  k;
    logic        p;
    logic        d;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [10:0] ex(input logic ll, input logic lr, input logic cl,
                                     input logic [1:0] o, input logic cs, input logic an,
                                     input logic er, input logic [2:0] st);
    return {ll, lr, cl, o, cs, an, er, st};
  endfunction

  function automatic logic [10:0] outs();
    return {load_left, load_right, clr, op, calc_start, ans_enable, err, state};
  endfunction

  task automatic add(input logic [3:0] k, input logic p, input logic d, input logic [10:0] e);
    vec_t v;
    v.k = k; v.p = p; v.d = d; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic drive(input logic [3:0] k, input logic p, input logic d);
    key = k; pressed = p; calc_done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    drive(k, 1'b1, 1'b0);
    drive(k, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    int cnt;
    key = 4'h0; pressed = 1'b0; calc_done = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(outs()), 32'(ex(0,0,0,2'b00,0,0,0,3'd0)));
    rst_n = 1'b1;

    // Basic add: 3 A 5 E, done four cycles after calc_start
    add(4'h0, 0, 0, ex(0,0,0,2'b00,0,0,0,3'd0));
    add(4'h3, 1, 0, ex(1,0,0,2'b00,0,0,0,3'd0));
    add(4'h3, 0, 0, ex(0,0,0,2'b00,0,0,0,3'd0));
    add(4'hA, 1, 0, ex(0,0,0,2'b00,0,0,0,3'd1));
    add(4'hA, 0, 0, ex(0,0,0,2'b00,0,0,0,3'd1));
    add(4'h5, 1, 0, ex(0,1,0,2'b00,0,0,0,3'd1));
    add(4'h5, 0, 0, ex(0,0,0,2'b00,0,0,0,3'd1));
    add(4'hE, 1, 0, ex(0,0,0,2'b00,1,0,0,3'd2));
    add(4'hE, 0, 0, ex(0,0,0,2'b00,0,0,0,3'd2));
    add(4'hE, 0, 0, ex(0,0,0,2'b00,0,0,0,3'd2));
    add(4'hE, 0, 0, ex(0,0,0,2'b00,0,0,0,3'd2));
    add(4'hE, 0, 1, ex(0,0,0,2'b00,0,1,0,3'd3));
    add(4'hE, 0, 0, ex(0,0,0,2'b00,0,1,0,3'd3));
    add(4'hF, 1, 0, ex(0,0,1,2'b00,0,0,0,3'd0));
    add(4'hF, 0, 0, ex(0,0,0,2'b00,0,0,0,3'd0));
    // Held 7, then B and E without a right operand
    add(4'h7, 1, 0, ex(1,0,0,2'b00,0,0,0,3'd0));
    add(4'h7, 1, 0, ex(0,0,0,2'b00,0,0,0,3'd0));
    add(4'h7, 1, 0, ex(0,0,0,2'b00,0,0,0,3'd0));
    add(4'h7, 0, 0, ex(0,0,0,2'b00,0,0,0,3'd0));
    add(4'hB, 1, 0, ex(0,0,0,2'b01,0,0,0,3'd1));
    add(4'hB, 0, 0, ex(0,0,0,2'b01,0,0,0,3'd1));
    add(4'hE, 1, 0, ex(0,0,0,2'b01,0,0,0,3'd1));
    add(4'hE, 0, 0, ex(0,0,0,2'b01,0,0,0,3'd1));
    // Operator overwrite A then C, then 6 E with done at minimum dwell
    add(4'hA, 1, 0, ex(0,0,0,2'b00,0,0,0,3'd1));
    add(4'hA, 0, 0, ex(0,0,0,2'b00,0,0,0,3'd1));
    add(4'hC, 1, 0, ex(0,0,0,2'b10,0,0,0,3'd1));
    add(4'hC, 0, 0, ex(0,0,0,2'b10,0,0,0,3'd1));
    add(4'h6, 1, 0, ex(0,1,0,2'b10,0,0,0,3'd1));
    add(4'h6, 0, 0, ex(0,0,0,2'b10,0,0,0,3'd1));
    add(4'hE, 1, 0, ex(0,0,0,2'b10,1,0,0,3'd2));
    add(4'hE, 0, 1, ex(0,0,0,2'b10,0,1,0,3'd3));
    // Non-digits ignored in S_SHOW, then a digit starts over with op held
    add(4'hD, 1, 0, ex(0,0,0,2'b10,0,1,0,3'd3));
    add(4'hD, 0, 0, ex(0,0,0,2'b10,0,1,0,3'd3));
    add(4'hE, 1, 0, ex(0,0,0,2'b10,0,1,0,3'd3));
    add(4'hE, 0, 0, ex(0,0,0,2'b10,0,1,0,3'd3));
    add(4'h2, 1, 0, ex(1,0,0,2'b10,0,0,0,3'd0));
    add(4'h2, 0, 1, ex(0,0,0,2'b10,0,0,0,3'd0));
    add(4'hE, 1, 0, ex(0,0,0,2'b10,0,0,0,3'd0));
    add(4'hE, 0, 0, ex(0,0,0,2'b10,0,0,0,3'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].k, vecs[i].p, vecs[i].d);
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Hold 7 for 50 cycles: exactly one load_left; then B, E with no right digit
    press(4'hF);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      drive(4'h7, 1'b1, 1'b0);
      if (load_left) cnt++;
    end
    drive(4'h7, 1'b0, 1'b0);
    check("held_key_loads", 32'(cnt), 32'd1);
    press(4'hB);
    cnt = 0;
    drive(4'hE, 1'b1, 1'b0);
    if (calc_start) cnt++;
    drive(4'hE, 1'b0, 1'b0);
    if (calc_start) cnt++;
    check("eq_no_right_start", 32'(cnt), 32'd0);
    check("eq_no_right_op", 32'(op), 32'd1);
    check("eq_no_right_state", 32'(state), 32'd1);

    // Timeout: 2 C 4 E, no calc_done
    press(4'hF);
    press(4'h2);
    press(4'hC);
    press(4'h4);
    drive(4'hE, 1'b1, 1'b0);
    check("to_start", 32'({calc_start, state}), 32'({1'b1, 3'd2}));
    n = 1;
    while (state == 3'd2 && n < 100) begin
      drive(4'hE, 1'b0, 1'b0);
      if (state == 3'd2) n++;
    end
    check("to_dwell", 32'(n), 32'd15);
    check("to_show", 32'({ans_enable, err, state}), 32'({1'b1, 1'b1, 3'd3}));
    drive(4'h9, 1'b1, 1'b0);
    check("to_digit", 32'({load_left, err, ans_enable, state}), 32'({1'b1, 1'b0, 1'b0, 3'd0}));
    drive(4'h9, 1'b0, 1'b0);

    // Clear on the same edge as calc_done
    press(4'hF);
    press(4'h1);
    press(4'hA);
    press(4'h2);
    drive(4'hE, 1'b1, 1'b0);
    drive(4'hE, 1'b0, 1'b0);
    check("clr_in_calc", 32'(state), 32'd2);
    drive(4'hF, 1'b1, 1'b1);
    check("clr_pri", 32'(outs()), 32'(ex(0,0,1,2'b00,0,0,0,3'd0)));
    drive(4'hF, 1'b0, 1'b0);
    check("clr_after", 32'(outs()), 32'(ex(0,0,0,2'b00,0,0,0,3'd0)));

    // Key 5 held through reset release
    key = 4'h5; pressed = 1'b1; calc_done = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_async", 32'(outs()), 32'(ex(0,0,0,2'b00,0,0,0,3'd0)));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      drive(4'h5, 1'b1, 1'b0);
      if (load_left || load_right || clr || calc_start) cnt++;
    end
    check("rst_held_strobes", 32'(cnt), 32'd0);
    drive(4'h5, 1'b0, 1'b0);
    cnt = 0;
    drive(4'h5, 1'b1, 1'b0);
    if (load_left) cnt++;
    drive(4'h5, 1'b1, 1'b0);
    if (load_left) cnt++;
    drive(4'h5, 1'b0, 1'b0);
    if (load_left) cnt++;
    check("rst_repress_loads", 32'(cnt), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
